// File: rtl/uart_alu_ctrl_pkg.sv
// Shared ALU opcode values and sequencer state encoding for the UART/ALU datapath.
// The ALU and the controller both take their opcode definitions from here.
package uart_alu_ctrl_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_legal_op = 1'b1;
            default:                        is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_ctrl_rx_timeout_counter.sv
// Inter-byte timeout: counts baud ticks while enabled and flags expiry on the
// tick that would take the count past LIMIT-1. Saturates instead of wrapping.
module rx_timeout_counter #(
    parameter int LIMIT = 640
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    input  logic tick,
    output logic expired
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_reg;
    logic             at_last;

    assign at_last = (count_reg == LAST);
    assign expired = enable && tick && at_last;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && tick && !at_last) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART receiver, ALU and UART transmitter: gathers A, B and
// opcode bytes, runs the ALU for one cycle, then hands the result to the transmitter.
module uart_alu_ctrl
    import uart_alu_ctrl_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int OP_W          = 6,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_tick,
    input  logic              i_rx_done,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic              i_tx_done,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    output logic [DATA_W-1:0] o_tx_data,
    output logic              o_tx_start,
    output logic              o_err,
    output logic              o_overrun,
    output logic              o_busy
);

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] a_reg, b_reg, tx_data_reg;
    logic [OP_W-1:0]   op_reg;
    logic              tx_start_reg, err_reg, overrun_reg;
    logic              err_next, overrun_next;

    logic [OP_W-1:0]   rx_op;
    logic              op_legal;
    logic              to_clear, to_enable, to_expired;

    assign rx_op    = i_rx_data[OP_W-1:0];
    assign op_legal = is_legal_op(6'(rx_op));

    // Holding clear throughout GET_A guarantees a fresh count for every frame.
    assign to_clear  = i_rx_done || (state_reg == GET_A) || to_expired;
    assign to_enable = (state_reg == GET_B) || (state_reg == GET_OP);

    rx_timeout_counter #(
        .LIMIT (TIMEOUT_TICKS)
    ) u_timeout (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .clear   (to_clear),
        .enable  (to_enable),
        .tick    (i_tick),
        .expired (to_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= GET_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // A received byte always takes priority over a timeout in the same cycle.
    always_comb begin
        state_next   = state_reg;
        err_next     = 1'b0;
        overrun_next = 1'b0;
        case (state_reg)
            GET_A: begin
                if (i_rx_done) state_next = GET_B;
            end
            GET_B: begin
                if (i_rx_done) begin
                    state_next = GET_OP;
                end else if (to_expired) begin
                    state_next = GET_A;
                    err_next   = 1'b1;
                end
            end
            GET_OP: begin
                if (i_rx_done) begin
                    if (op_legal) begin
                        state_next = EXEC;
                    end else begin
                        state_next = GET_A;
                        err_next   = 1'b1;
                    end
                end else if (to_expired) begin
                    state_next = GET_A;
                    err_next   = 1'b1;
                end
            end
            EXEC: begin
                state_next   = SEND;
                overrun_next = i_rx_done;
            end
            SEND: begin
                state_next   = WAIT_TX;
                overrun_next = i_rx_done;
            end
            WAIT_TX: begin
                overrun_next = i_rx_done;
                if (i_tx_done) state_next = GET_A;
            end
            default: state_next = GET_A;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            op_reg       <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
            err_reg      <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (state_reg == GET_A && i_rx_done) a_reg <= i_rx_data;
            if (state_reg == GET_B && i_rx_done) b_reg <= i_rx_data;
            if (state_reg == GET_OP && i_rx_done && op_legal) op_reg <= rx_op;
            if (state_reg == EXEC) tx_data_reg <= i_alu_result;
            // Registered so the request lines up with the SEND state.
            tx_start_reg <= (state_reg == EXEC);
            err_reg      <= err_next;
            overrun_reg  <= overrun_next;
        end
    end

    assign o_alu_a    = a_reg;
    assign o_alu_b    = b_reg;
    assign o_alu_op   = op_reg;
    assign o_tx_data  = tx_data_reg;
    assign o_tx_start = tx_start_reg;
    assign o_err      = err_reg;
    assign o_overrun  = overrun_reg;
    assign o_busy     = (state_reg == EXEC) || (state_reg == SEND) || (state_reg == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Scoreboard bench for uart_alu_ctrl: a frame-level model predicts transmit
// requests, error and overrun pulses; a monitor matches them as they appear.
module tb_uart_alu_ctrl;

    localparam int TIMEOUT = 640;

    logic       i_clk;
    logic       i_reset;
    logic       i_tick;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_err;
    logic       o_overrun;
    logic       o_busy;

    uart_alu_ctrl #(
        .DATA_W        (8),
        .OP_W          (6),
        .TIMEOUT_TICKS (TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_tick       (i_tick),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_alu_result (i_alu_result),
        .i_tx_done    (i_tx_done),
        .o_alu_a      (o_alu_a),
        .o_alu_b      (o_alu_b),
        .o_alu_op     (o_alu_op),
        .o_tx_data    (o_tx_data),
        .o_tx_start   (o_tx_start),
        .o_err        (o_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic legal(input logic [5:0] op);
        case (op)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
        case (op)
            6'h20:   alu = a + b;
            6'h22:   alu = a - b;
            6'h24:   alu = a & b;
            6'h25:   alu = a | b;
            6'h26:   alu = a ^ b;
            6'h27:   alu = ~(a | b);
            6'h03:   alu = 8'($signed(a) >>> b);
            6'h02:   alu = a >> b;
            default: alu = 8'h00;
        endcase
    endfunction

    // Stand-in for the external ALU
    always_comb i_alu_result = alu(o_alu_a, o_alu_b, o_alu_op);

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
    } tx_exp_t;

    tx_exp_t tx_q[$];
    int      err_q[$];
    int      ovr_q[$];
    tx_exp_t mon_e;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Frame-level model state
    int         m_idx;
    int         m_ticks;
    logic       m_busy;
    int         m_busy_cyc;
    logic [7:0] m_a, m_b;
    logic [5:0] m_last_op;

    task automatic model_reset();
        m_idx = 0; m_ticks = 0; m_busy = 1'b0; m_busy_cyc = 0;
    endtask

    task automatic model_apply(input logic rx, input logic [7:0] d,
                               input logic tk, input logic txd);
        tx_exp_t    e;
        logic       was_busy;
        logic [5:0] op;
        was_busy = m_busy;
        if (rx) begin
            if (was_busy) begin
                ovr_q.push_back(cyc + 1);
            end else begin
                m_ticks = 0;
                if (m_idx == 0) begin
                    m_a = d; m_idx = 1;
                end else if (m_idx == 1) begin
                    m_b = d; m_idx = 2;
                end else begin
                    op = d[5:0];
                    m_idx = 0;
                    if (legal(op)) begin
                        e.cyc = cyc + 2; e.data = alu(m_a, m_b, op);
                        e.a = m_a; e.b = m_b; e.op = op;
                        tx_q.push_back(e);
                        m_last_op = op;
                        m_busy = 1'b1; m_busy_cyc = cyc;
                    end else begin
                        err_q.push_back(cyc + 1);
                    end
                end
            end
        end else if (tk && !was_busy && m_idx != 0) begin
            m_ticks++;
            if (m_ticks == TIMEOUT) begin
                err_q.push_back(cyc + 1);
                m_idx = 0; m_ticks = 0;
            end
        end
        if (txd && was_busy && cyc >= m_busy_cyc + 3) m_busy = 1'b0;
    endtask

    task automatic step(input logic rx, input logic [7:0] d,
                        input logic tk, input logic txd);
        i_rx_done = rx;
        i_rx_data = rx ? d : 8'h00;
        i_tick    = tk;
        i_tx_done = txd;
        model_apply(rx, d, tk, txd);
        @(posedge i_clk);
        #1;
        i_rx_done = 1'b0;
        i_tick    = 1'b0;
        i_tx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        step(1'b1, a, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, op, 1'b0, 1'b0);
    endtask

    task automatic finish_tx();
        idle(4);
        step(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s = %0h ok", name, act);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " o_alu_a"},    int'(o_alu_a),    0);
        check({tag, " o_alu_b"},    int'(o_alu_b),    0);
        check({tag, " o_alu_op"},   int'(o_alu_op),   0);
        check({tag, " o_tx_data"},  int'(o_tx_data),  0);
        check({tag, " o_tx_start"}, int'(o_tx_start), 0);
        check({tag, " o_err"},      int'(o_err),      0);
        check({tag, " o_overrun"},  int'(o_overrun),  0);
        check({tag, " o_busy"},     int'(o_busy),     0);
    endtask

    task automatic mid_reset(input string tag);
        #2;
        i_reset = 1'b0;
        #1;
        check_all_zero(tag);
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        model_reset();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: match every output pulse against the scoreboard queues
    always @(negedge i_clk) begin
        if (i_reset) begin
            if (o_tx_start) begin
                n_checks++;
                if (tx_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL tx_start: unexpected pulse at cycle %0d data %02h", cyc, o_tx_data);
                end else begin
                    mon_e = tx_q.pop_front();
                    if (mon_e.cyc != cyc || o_tx_data !== mon_e.data || o_alu_a !== mon_e.a ||
                        o_alu_b !== mon_e.b || o_alu_op !== mon_e.op || o_busy !== 1'b1) begin
                        n_errors++;
                        $display("FAIL tx_start: got cyc %0d data %02h a %02h b %02h op %02h busy %0b expected cyc %0d data %02h a %02h b %02h op %02h busy 1",
                                 cyc, o_tx_data, o_alu_a, o_alu_b, o_alu_op, o_busy,
                                 mon_e.cyc, mon_e.data, mon_e.a, mon_e.b, mon_e.op);
                    end else begin
                        $display("tx cycle %0d a %02h b %02h op %02h -> %02h ok",
                                 cyc, o_alu_a, o_alu_b, o_alu_op, o_tx_data);
                    end
                end
            end
            if (o_err) begin
                n_checks++;
                if (err_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL err: unexpected pulse at cycle %0d", cyc);
                end else if (err_q[0] != cyc) begin
                    n_errors++;
                    $display("FAIL err: pulse at cycle %0d expected cycle %0d", cyc, err_q[0]);
                    void'(err_q.pop_front());
                end else begin
                    void'(err_q.pop_front());
                    $display("err pulse cycle %0d ok", cyc);
                end
            end
            if (o_overrun) begin
                n_checks++;
                if (ovr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL overrun: unexpected pulse at cycle %0d", cyc);
                end else if (ovr_q[0] != cyc) begin
                    n_errors++;
                    $display("FAIL overrun: pulse at cycle %0d expected cycle %0d", cyc, ovr_q[0]);
                    void'(ovr_q.pop_front());
                end else begin
                    void'(ovr_q.pop_front());
                    $display("overrun pulse cycle %0d ok", cyc);
                end
            end
            if (tx_q.size() > 0 && tx_q[0].cyc < cyc) begin
                n_checks++; n_errors++;
                $display("FAIL tx_start: missing, got none expected at cycle %0d", tx_q[0].cyc);
                void'(tx_q.pop_front());
            end
            if (err_q.size() > 0 && err_q[0] < cyc) begin
                n_checks++; n_errors++;
                $display("FAIL err: missing, got none expected at cycle %0d", err_q[0]);
                void'(err_q.pop_front());
            end
            if (ovr_q.size() > 0 && ovr_q[0] < cyc) begin
                n_checks++; n_errors++;
                $display("FAIL overrun: missing, got none expected at cycle %0d", ovr_q[0]);
                void'(ovr_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] ra, rb, rop;
        int         guard;
        i_reset = 1'b0; i_tick = 1'b0; i_rx_done = 1'b0;
        i_rx_data = 8'h00; i_tx_done = 1'b0;
        m_a = 8'h00; m_b = 8'h00; m_last_op = 6'h00;
        model_reset();
        #12;
        check_all_zero("reset");
        @(posedge i_clk);
        #2;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;

        // Basic ADD frame
        frame(8'h05, 8'h03, 8'h20);
        finish_tx();

        // Illegal opcode keeps A, B and the previous opcode
        frame(8'h10, 8'h20, 8'h3F);
        idle(2);
        check("illegal keeps a", int'(o_alu_a), 'h10);
        check("illegal keeps b", int'(o_alu_b), 'h20);
        check("illegal keeps op", int'(o_alu_op), 'h20);
        frame(8'h07, 8'h02, 8'h22);
        finish_tx();

        // Timeout after operand A, next byte starts a new frame
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        ticks(TIMEOUT);
        idle(2);
        frame(8'h11, 8'h0F, 8'h24);
        finish_tx();

        // Expiry tick coinciding with operand B: byte wins
        step(1'b1, 8'h01, 1'b0, 1'b0);
        ticks(TIMEOUT - 1);
        step(1'b1, 8'h09, 1'b1, 1'b0);
        ticks(5);
        step(1'b1, 8'h25, 1'b0, 1'b0);
        finish_tx();

        // Overrun in WAIT_TX, then a clean frame
        frame(8'h40, 8'h30, 8'h26);
        idle(4);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        frame(8'h0C, 8'h0A, 8'h27);
        finish_tx();

        // Reset in GET_OP and in WAIT_TX, then SRL recovery frame
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b1, 8'h34, 1'b0, 1'b0);
        mid_reset("rst getop");
        frame(8'h01, 8'h02, 8'h20);
        idle(4);
        mid_reset("rst waittx");
        frame(8'hF0, 8'h04, 8'h02);
        finish_tx();

        // Randomised frames with stray ticks, stray tx_done and overruns
        for (int f = 0; f < 40; f++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rop = 8'h20; 1: rop = 8'h22; 2: rop = 8'h24; 3: rop = 8'h25;
                4: rop = 8'h26; 5: rop = 8'h27; 6: rop = 8'h03; 7: rop = 8'h02;
                default: rop = 8'($urandom);
            endcase
            step(1'b1, ra, ($urandom_range(0, 3) == 0), 1'b0);
            for (int g = 0; g < $urandom_range(0, 6); g++)
                step(1'b0, 8'h00, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            step(1'b1, rb, ($urandom_range(0, 3) == 0), 1'b0);
            for (int g = 0; g < $urandom_range(0, 6); g++)
                step(1'b0, 8'h00, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            step(1'b1, rop, 1'b0, 1'b0);
            guard = 0;
            while (m_busy && guard < 200) begin
                step(($urandom_range(0, 5) == 0), 8'($urandom), 1'b0, ($urandom_range(0, 2) == 0));
                guard++;
            end
            if (f % 13 == 5) begin
                step(1'b1, 8'($urandom), 1'b0, 1'b0);
                if (f % 2 == 1) step(1'b1, 8'($urandom), 1'b0, 1'b0);
                ticks(TIMEOUT);
            end
            idle(2);
        end

        idle(5);
        check("tx queue drained", tx_q.size(), 0);
        check("err queue drained", err_q.size(), 0);
        check("overrun queue drained", ovr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
